uart_boot_loader: RTL and testbench



---
 rtl/uart_boot_pkg.sv | 30 +++
 rtl/uart_rx_core.sv | 99 +++++++++
 rtl/uart_boot_loader.sv | 195 +++++++++++++++++++
 tb/tb_uart_boot_loader.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_boot_pkg.sv
package uart_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN_LO,
    ST_LEN_HI,
    ST_DATA,
    ST_CSUM,
    ST_FINISH
  } loader_state_e;

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_STOP
  } rx_state_e;

  localparam logic [7:0] HDR_BYTE_DEFAULT = 8'hA5;

  function automatic int unsigned bytes_per_word(input int unsigned xlen);
    return xlen / 8;
  endfunction

  // Wide enough to hold the value `cycles` itself, not just cycles-1.
  function automatic int unsigned timeout_width(input int unsigned cycles);
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
module uart_rx_core
  import uart_boot_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_in,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int unsigned     CNT_W     = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  rx_state_e        state_q, state_d;
  logic             sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_in;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (prev_q && !sync2_q) state_d = RX_START;
      end
      RX_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = sync2_q ? RX_IDLE : RX_DATA;
        end
      end
      RX_DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d     = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 1'b1;
          if (bit_idx_q == 3'd7) state_d = RX_STOP;
        end
      end
      RX_STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d   = '0;
          state_d = RX_IDLE;
          valid_d = sync2_q;
          ferr_d  = !sync2_q;
        end
      end
      default: state_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= RX_IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
    end
  end

  assign byte_valid = valid_q;
  assign byte_data  = shift_q;
  assign frame_err  = ferr_q;

endmodule

// File: rtl/uart_boot_loader.sv
module uart_boot_loader
  import uart_boot_pkg::*;
#(
  parameter int unsigned          CLKS_PER_BIT = 434,
  parameter int unsigned          XLEN         = 32,
  parameter int unsigned          ADDR_WIDTH   = 16,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter logic [7:0]           HDR_BYTE     = HDR_BYTE_DEFAULT,
  parameter int unsigned          TIMEOUT_BITS = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rx_in,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [XLEN-1:0]       wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [ADDR_WIDTH-1:0] words_loaded
);

  localparam int unsigned BPW        = bytes_per_word(XLEN);
  localparam int unsigned IDX_W      = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned TMO_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int unsigned TMO_W      = timeout_width(TMO_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TMO_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BPW - 1);

  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_in     (rx_in),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  loader_state_e         state_q, state_d;
  logic [7:0]            len_lo_q, len_lo_d;
  logic [15:0]           words_left_q, words_left_d;
  logic [IDX_W-1:0]      byte_idx_q, byte_idx_d;
  logic [XLEN-1:0]       word_q, word_d;
  logic [7:0]            csum_q, csum_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] words_loaded_q, words_loaded_d;
  logic [TMO_W-1:0]      tmr_q, tmr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [XLEN-1:0]       wr_data_q, wr_data_d;
  logic                  in_frame;
  logic                  abort;

  always_comb begin
    in_frame       = state_q inside {ST_LEN_LO, ST_LEN_HI, ST_DATA, ST_CSUM};
    abort          = in_frame && (frame_err || (tmr_q == TMO_LAST));
    tmr_d          = (byte_valid || !in_frame) ? '0 : tmr_q + 1'b1;
    state_d        = state_q;
    len_lo_d       = len_lo_q;
    words_left_d   = words_left_q;
    byte_idx_d     = byte_idx_q;
    word_d         = word_q;
    csum_d         = csum_q;
    addr_d         = addr_q;
    words_loaded_d = words_loaded_q;
    busy_d         = busy_q;
    done_d         = done_q;
    err_d          = err_q;
    wr_en_d        = 1'b0;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;

    case (state_q)
      ST_IDLE: begin
        if (byte_valid && byte_data == HDR_BYTE) begin
          state_d        = ST_LEN_LO;
          busy_d         = 1'b1;
          done_d         = 1'b0;
          err_d          = 1'b0;
          words_loaded_d = '0;
          addr_d         = BASE_ADDR;
          byte_idx_d     = '0;
          csum_d         = '0;
        end
      end
      ST_LEN_LO: begin
        if (byte_valid) begin
          len_lo_d = byte_data;
          state_d  = ST_LEN_HI;
        end
      end
      ST_LEN_HI: begin
        if (byte_valid) begin
          words_left_d = {byte_data, len_lo_q};
          state_d      = ({byte_data, len_lo_q} == 16'd0) ? ST_CSUM : ST_DATA;
        end
      end
      ST_DATA: begin
        if (byte_valid) begin
          csum_d = csum_q + byte_data;
          for (int unsigned i = 0; i < BPW; i++) begin
            if (byte_idx_q == IDX_W'(i)) word_d[i*8 +: 8] = byte_data;
          end
          if (byte_idx_q == IDX_LAST) begin
            byte_idx_d     = '0;
            wr_en_d        = 1'b1;
            wr_addr_d      = addr_q;
            wr_data_d      = word_d;
            addr_d         = addr_q + 1'b1;
            words_loaded_d = words_loaded_q + 1'b1;
            words_left_d   = words_left_q - 1'b1;
            if (words_left_q == 16'd1) state_d = ST_CSUM;
          end else begin
            byte_idx_d = byte_idx_q + 1'b1;
          end
        end
      end
      ST_CSUM: begin
        if (byte_valid) begin
          state_d = ST_FINISH;
          busy_d  = 1'b0;
          if (byte_data == csum_q) done_d = 1'b1;
          else                     err_d  = 1'b1;
        end
      end
      ST_FINISH: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      err_d   = 1'b1;
      wr_en_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      len_lo_q       <= '0;
      words_left_q   <= '0;
      byte_idx_q     <= '0;
      word_q         <= '0;
      csum_q         <= '0;
      addr_q         <= '0;
      words_loaded_q <= '0;
      tmr_q          <= '0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      err_q          <= 1'b0;
      wr_en_q        <= 1'b0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
    end else begin
      state_q        <= state_d;
      len_lo_q       <= len_lo_d;
      words_left_q   <= words_left_d;
      byte_idx_q     <= byte_idx_d;
      word_q         <= word_d;
      csum_q         <= csum_d;
      addr_q         <= addr_d;
      words_loaded_q <= words_loaded_d;
      tmr_q          <= tmr_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      err_q          <= err_d;
      wr_en_q        <= wr_en_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_loaded_q;

endmodule

// File: tb/tb_uart_boot_loader.sv
module tb_uart_boot_loader;

  localparam int unsigned CPB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic rx0 = 1'b1, rx1 = 1'b1, rx2 = 1'b1;

  logic        wr_en0, busy0, done0, err0;
  logic [15:0] wr_addr0, words0;
  logic [31:0] wr_data0;
  logic        wr_en1, busy1, done1, err1;
  logic [15:0] wr_addr1, words1;
  logic [31:0] wr_data1;
  logic        wr_en2, busy2, done2, err2;
  logic [1:0]  wr_addr2, words2;
  logic [15:0] wr_data2;

  int unsigned checks = 0;
  int unsigned errors = 0;
  logic [47:0] q0[$];
  logic [17:0] q2[$];
  logic [7:0]  tx_q[$];

  always #5 clk = ~clk;

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB), .XLEN(32), .ADDR_WIDTH(16), .BASE_ADDR(16'h0010),
    .HDR_BYTE(8'hA5), .TIMEOUT_BITS(64)
  ) dut0 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx0), .wr_en(wr_en0), .wr_addr(wr_addr0),
    .wr_data(wr_data0), .busy(busy0), .done(done0), .err(err0), .words_loaded(words0)
  );

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB), .XLEN(32), .ADDR_WIDTH(16), .BASE_ADDR(16'h0000),
    .HDR_BYTE(8'hA5), .TIMEOUT_BITS(12)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx1), .wr_en(wr_en1), .wr_addr(wr_addr1),
    .wr_data(wr_data1), .busy(busy1), .done(done1), .err(err1), .words_loaded(words1)
  );

  uart_boot_loader #(
    .CLKS_PER_BIT(CPB), .XLEN(16), .ADDR_WIDTH(2), .BASE_ADDR(2'd3),
    .HDR_BYTE(8'hA5), .TIMEOUT_BITS(64)
  ) dut2 (
    .clk(clk), .rst_n(rst_n), .rx_in(rx2), .wr_en(wr_en2), .wr_addr(wr_addr2),
    .wr_data(wr_data2), .busy(busy2), .done(done2), .err(err2), .words_loaded(words2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wr_en0) begin
      chk("dut0_wr_expected", 64'(q0.size() != 0), 64'd1);
      if (q0.size() != 0) chk("dut0_wr_addr_data", {16'h0, wr_addr0, wr_data0}, {16'h0, q0.pop_front()});
    end
    if (rst_n && wr_en1) chk("dut1_no_write", 64'(wr_en1), 64'd0);
    if (rst_n && wr_en2) begin
      chk("dut2_wr_expected", 64'(q2.size() != 0), 64'd1);
      if (q2.size() != 0) chk("dut2_wr_addr_data", {46'h0, wr_addr2, wr_data2}, {46'h0, q2.pop_front()});
    end
  end

  task automatic drive(input int unsigned ch, input logic v);
    case (ch)
      0:       rx0 = v;
      1:       rx1 = v;
      default: rx2 = v;
    endcase
  endtask

  task automatic send_byte(input int unsigned ch, input logic [7:0] b, input logic stop_bit);
    drive(ch, 1'b0);
    repeat (CPB) @(posedge clk);
    for (int unsigned i = 0; i < 8; i++) begin
      drive(ch, b[i]);
      repeat (CPB) @(posedge clk);
    end
    drive(ch, stop_bit);
    repeat (CPB) @(posedge clk);
    drive(ch, 1'b1);
    repeat (2) @(posedge clk);
  endtask

  task automatic send_frame(input int unsigned ch);
    foreach (tx_q[i]) send_byte(ch, tx_q[i], 1'b1);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle(3);
    chk("rst_wr_en",   64'(wr_en0),   64'd0);
    chk("rst_wr_addr", 64'(wr_addr0), 64'd0);
    chk("rst_wr_data", 64'(wr_data0), 64'd0);
    chk("rst_busy",    64'(busy0),    64'd0);
    chk("rst_done",    64'(done0),    64'd0);
    chk("rst_err",     64'(err0),     64'd0);
    chk("rst_words",   64'(words0),   64'd0);
    chk("rst_err1",    64'(err1),     64'd0);
    chk("rst_addr2",   64'(wr_addr2), 64'd0);
    @(negedge clk) rst_n = 1'b1;
    idle(4);

    // Noise, then a good frame; payload sum 13+93+10 = B6.
    q0.push_back({16'h0010, 32'h0000_0013});
    q0.push_back({16'h0011, 32'h0010_0093});
    send_byte(0, 8'h00, 1'b1);
    send_byte(0, 8'hFF, 1'b1);
    idle(4);
    chk("noise_busy", 64'(busy0), 64'd0);
    send_byte(0, 8'hA5, 1'b1);
    idle(2);
    chk("hdr_busy", 64'(busy0), 64'd1);
    tx_q = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_frame(0);
    idle(8);
    chk("good_done",  64'(done0),     64'd1);
    chk("good_err",   64'(err0),      64'd0);
    chk("good_busy",  64'(busy0),     64'd0);
    chk("good_words", 64'(words0),    64'd2);
    chk("good_q",     64'(q0.size()), 64'd0);

    // Bad checksum: writes still happen.
    q0.push_back({16'h0010, 32'h0000_0013});
    q0.push_back({16'h0011, 32'h0010_0093});
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'h00};
    send_frame(0);
    idle(8);
    chk("bad_err",   64'(err0),      64'd1);
    chk("bad_done",  64'(done0),     64'd0);
    chk("bad_words", 64'(words0),    64'd2);
    chk("bad_q",     64'(q0.size()), 64'd0);

    // Framing error on the 3rd payload byte; later bytes must not write.
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    send_frame(0);
    send_byte(0, 8'h00, 1'b0);
    idle(8);
    chk("ferr_err",   64'(err0),   64'd1);
    chk("ferr_busy",  64'(busy0),  64'd0);
    chk("ferr_done",  64'(done0),  64'd0);
    chk("ferr_words", 64'(words0), 64'd0);
    tx_q = '{8'h00, 8'h93, 8'h00, 8'h10};
    send_frame(0);
    idle(8);
    chk("ferr_idle_busy", 64'(busy0), 64'd0);
    chk("ferr_idle_err",  64'(err0),  64'd1);

    // Recovery frame after the abort.
    q0.push_back({16'h0010, 32'h0000_0013});
    q0.push_back({16'h0011, 32'h0010_0093});
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00, 8'hB6};
    send_frame(0);
    idle(8);
    chk("recov_done", 64'(done0),     64'd1);
    chk("recov_err",  64'(err0),      64'd0);
    chk("recov_q",    64'(q0.size()), 64'd0);

    // Zero-length frame.
    tx_q = '{8'hA5, 8'h00, 8'h00, 8'h00};
    send_frame(0);
    idle(8);
    chk("n0_done",  64'(done0),  64'd1);
    chk("n0_err",   64'(err0),   64'd0);
    chk("n0_words", 64'(words0), 64'd0);

    // Address wrap with 16-bit words: 34+12+78+56 = 0x114 -> 14.
    q2.push_back({2'd3, 16'h1234});
    q2.push_back({2'd0, 16'h5678});
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h34, 8'h12, 8'h78, 8'h56, 8'h14};
    send_frame(2);
    idle(8);
    chk("wrap_done",  64'(done2),     64'd1);
    chk("wrap_err",   64'(err2),      64'd0);
    chk("wrap_words", 64'(words2),    64'd2);
    chk("wrap_q",     64'(q2.size()), 64'd0);

    // Timeout of 96 cycles; the timer restarts on each byte.
    tx_q = '{8'hA5, 8'h01, 8'h00, 8'h11};
    send_frame(1);
    idle(1);
    chk("tmo_busy_live", 64'(busy1), 64'd1);
    idle(70);
    chk("tmo_not_yet", 64'(err1), 64'd0);
    for (int i = 0; i < 60 && !err1; i++) @(posedge clk);
    #1;
    chk("tmo_err",   64'(err1),   64'd1);
    chk("tmo_busy",  64'(busy1),  64'd0);
    chk("tmo_words", 64'(words1), 64'd0);

    // Async reset in the middle of DATA.
    q0.push_back({16'h0010, 32'h4433_2211});
    tx_q = '{8'hA5, 8'h02, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_frame(0);
    idle(1);
    chk("mid_busy",  64'(busy0),  64'd1);
    chk("mid_words", 64'(words0), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy",  64'(busy0),  64'd0);
    chk("arst_wr_en", 64'(wr_en0), 64'd0);
    chk("arst_words", 64'(words0), 64'd0);
    chk("arst_done",  64'(done0),  64'd0);
    idle(3);
    @(negedge clk) rst_n = 1'b1;
    idle(4);
    chk("end_q0", 64'(q0.size()), 64'd0);
    chk("end_q2", 64'(q2.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
